// File: rtl/apb3_master_arbiter.sv
// APB3 master shared by NUM_REQ requesters through a round-robin arbiter.
// One transfer is in flight at a time. Completion and timeout are reported to the owning requester.
module apb3_master_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 16
) (
   input  logic                           PCLK,
   input  logic                           PRESETn,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             req_grant,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_rdata,
   output logic                           rsp_err,
   output logic                           rsp_timeout,
   output logic [ADDR_WIDTH-1:0]          PADDR,
   output logic [DATA_WIDTH-1:0]          PWDATA,
   output logic                           PSELx,
   output logic                           PENABLE,
   output logic                           PWRITE,
   input  logic                           PREADY,
   input  logic [DATA_WIDTH-1:0]          PRDATA,
   input  logic                           PSLVERR
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_WAIT + 1);

   // The state names the bus phase that the next edge drives. Because of this, the grant
   // cycle comes one cycle before SETUP on the bus, and SETUP comes one cycle before ACCESS.
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_owner;
   logic [CW-1:0]   r_cnt;

   logic            w_any;
   logic [PW-1:0]   w_win;
   logic [NUM_REQ-1:0] w_win_oh;
   logic [PW-1:0]   w_ptr_nxt;

   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_any && req_valid[idx]) begin
            w_any = 1'b1;
            w_win = PW'(idx);
         end
      end
   end

   assign w_win_oh  = NUM_REQ'(1) << w_win;
   assign w_ptr_nxt = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_cnt       <= '0;
         req_grant   <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSELx       <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
      end else begin
         req_grant   <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               PSELx   <= 1'b0;
               PENABLE <= 1'b0;
               if (w_any) begin
                  req_grant <= w_win_oh;
                  r_owner   <= w_win;
                  r_ptr     <= w_ptr_nxt;
                  PADDR     <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                  PWDATA    <= req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
                  PWRITE    <= req_write[w_win];
                  r_state   <= SETUP;
               end
            end
            SETUP: begin
               PSELx   <= 1'b1;
               PENABLE <= 1'b0;
               r_cnt   <= '0;
               r_state <= ACCESS;
            end
            ACCESS: begin
               if (!PENABLE) begin
                  PENABLE <= 1'b1;
               end else if (PREADY) begin
                  rsp_valid <= NUM_REQ'(1) << r_owner;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_err   <= PSLVERR;
                  PENABLE   <= 1'b0;
                  if (w_any) begin
                     // Back-to-back: the next transfer's SETUP starts in its grant cycle.
                     req_grant <= w_win_oh;
                     r_owner   <= w_win;
                     r_ptr     <= w_ptr_nxt;
                     PADDR     <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                     PWDATA    <= req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
                     PWRITE    <= req_write[w_win];
                     r_cnt     <= '0;
                     r_state   <= ACCESS;
                  end else begin
                     PSELx   <= 1'b0;
                     r_state <= IDLE;
                  end
               end else if (r_cnt == CW'(MAX_WAIT - 1)) begin
                  rsp_valid   <= NUM_REQ'(1) << r_owner;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  PSELx       <= 1'b0;
                  PENABLE     <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
